// File: rtl/arm_pkg.sv
// ARM data-processing definitions shared by the decoder and the execute stage.
package arm_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NZCV_W     = 4;
    localparam int unsigned OPCODE_W   = 4;
    localparam int unsigned COND_W     = 4;
    localparam int unsigned REG_ADDR_W = 4;

    // NZCV bit positions inside the 4-bit flags vector
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [OPCODE_W-1:0] {
        OP_AND = 4'h0,
        OP_EOR = 4'h1,
        OP_SUB = 4'h2,
        OP_RSB = 4'h3,
        OP_ADD = 4'h4,
        OP_ADC = 4'h5,
        OP_SBC = 4'h6,
        OP_RSC = 4'h7,
        OP_TST = 4'h8,
        OP_TEQ = 4'h9,
        OP_CMP = 4'hA,
        OP_CMN = 4'hB,
        OP_ORR = 4'hC,
        OP_MOV = 4'hD,
        OP_BIC = 4'hE,
        OP_MVN = 4'hF
    } alu_op_e;

    typedef enum logic [COND_W-1:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    // Registered contents of the execute output slot
    typedef struct packed {
        logic [DATA_W-1:0]     result;
        logic [REG_ADDR_W-1:0] rd;
        logic                  write_en;
        logic                  cond_pass;
    } exec_slot_t;

    // Compare-class ops set flags unconditionally and never write Rd
    function automatic logic is_compare(input logic [OPCODE_W-1:0] op);
        return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
    endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluation against an NZCV vector.
module cond_check
    import arm_pkg::*;
(
    input  logic [COND_W-1:0] cond,
    input  logic [NZCV_W-1:0] flags,
    output logic              pass_c
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass_c = 1'b0;
        case (cond)
            COND_EQ: pass_c = z;
            COND_NE: pass_c = !z;
            COND_CS: pass_c = c;
            COND_CC: pass_c = !c;
            COND_MI: pass_c = n;
            COND_PL: pass_c = !n;
            COND_VS: pass_c = v;
            COND_VC: pass_c = !v;
            COND_HI: pass_c = c && !z;
            COND_LS: pass_c = !c || z;
            COND_GE: pass_c = (n == v);
            COND_LT: pass_c = (n != v);
            COND_GT: pass_c = !z && (n == v);
            COND_LE: pass_c = z || (n != v);
            COND_AL: pass_c = 1'b1;
            COND_NV: pass_c = 1'b0;
            default: pass_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_execute_stage.sv
// ARM execute stage: condition check, 16-op ALU, one-slot valid/ready output
// register and the architectural NZCV flags register.
module alu_execute_stage
    import arm_pkg::*;
#(
    parameter logic [NZCV_W-1:0] RESET_FLAGS = 4'b0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic [COND_W-1:0]     cond,
    input  logic                  s_bit,
    input  logic [DATA_W-1:0]     rn_data,
    input  logic [DATA_W-1:0]     op2,
    input  logic                  shifter_carry,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  flags_wr_en,
    input  logic [NZCV_W-1:0]     flags_wr_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     result,
    output logic [REG_ADDR_W-1:0] result_rd,
    output logic                  write_en,
    output logic                  cond_pass,
    output logic [NZCV_W-1:0]     flags
);

    logic              accept;
    logic              cond_ok_c;
    logic              is_cmp;
    logic              flag_update;
    logic              is_arith;
    logic              carry_in;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] alu_result;
    logic [NZCV_W-1:0] alu_flags;
    exec_slot_t        slot_q;

    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;
    assign is_cmp      = is_compare(opcode);
    assign flag_update = accept && cond_ok_c && (s_bit || is_cmp);

    cond_check u_cond_check (
        .cond   (cond),
        .flags  (flags),
        .pass_c (cond_ok_c)
    );

    // Adder operand selection: subtraction is A + ~B + cin, reverse forms swap A/B
    always_comb begin
        op_a     = rn_data;
        op_b     = op2;
        carry_in = 1'b0;
        is_arith = 1'b0;
        case (opcode)
            OP_SUB, OP_CMP: begin
                op_b     = ~op2;
                carry_in = 1'b1;
                is_arith = 1'b1;
            end
            OP_RSB: begin
                op_a     = op2;
                op_b     = ~rn_data;
                carry_in = 1'b1;
                is_arith = 1'b1;
            end
            OP_ADD, OP_CMN: begin
                is_arith = 1'b1;
            end
            OP_ADC: begin
                carry_in = flags[FLAG_C];
                is_arith = 1'b1;
            end
            OP_SBC: begin
                op_b     = ~op2;
                carry_in = flags[FLAG_C];
                is_arith = 1'b1;
            end
            OP_RSC: begin
                op_a     = op2;
                op_b     = ~rn_data;
                carry_in = flags[FLAG_C];
                is_arith = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign sum = {1'b0, op_a} + {1'b0, op_b} + (DATA_W + 1)'(carry_in);

    // Result mux and the NZCV the instruction would produce
    always_comb begin
        alu_result = sum[DATA_W-1:0];
        case (opcode)
            OP_AND, OP_TST: alu_result = rn_data & op2;
            OP_EOR, OP_TEQ: alu_result = rn_data ^ op2;
            OP_ORR:         alu_result = rn_data | op2;
            OP_MOV:         alu_result = op2;
            OP_BIC:         alu_result = rn_data & ~op2;
            OP_MVN:         alu_result = ~op2;
            default:        alu_result = sum[DATA_W-1:0];
        endcase

        alu_flags         = flags;
        alu_flags[FLAG_N] = alu_result[DATA_W-1];
        alu_flags[FLAG_Z] = (alu_result == '0);
        if (is_arith) begin
            alu_flags[FLAG_C] = sum[DATA_W];
            alu_flags[FLAG_V] = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                                (sum[DATA_W-1] != op_a[DATA_W-1]);
        end else begin
            alu_flags[FLAG_C] = shifter_carry;
            alu_flags[FLAG_V] = flags[FLAG_V];
        end
    end

    // Output slot and flags register; an instruction's flag update beats a direct load
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            slot_q    <= '0;
            flags     <= RESET_FLAGS;
        end else begin
            if (accept) begin
                out_valid        <= 1'b1;
                slot_q.result    <= alu_result;
                slot_q.rd        <= rd_addr;
                slot_q.write_en  <= cond_ok_c && !is_cmp;
                slot_q.cond_pass <= cond_ok_c;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (flag_update) begin
                flags <= alu_flags;
            end else if (flags_wr_en) begin
                flags <= flags_wr_data;
            end
        end
    end

    assign result    = slot_q.result;
    assign result_rd = slot_q.rd;
    assign write_en  = slot_q.write_en;
    assign cond_pass = slot_q.cond_pass;

endmodule
